// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control unit: opcodes, FSM states,
// and the ALU and register-file write-source encodings.
package proc_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT,
        FETCH,
        DECODE,
        MOVRD,
        MOVDR,
        ADD,
        MOVRC,
        SUB,
        JMPZ,
        HALT
    } state_t;

    localparam int unsigned OP_MOV_RD = 0;
    localparam int unsigned OP_MOV_DR = 1;
    localparam int unsigned OP_ADD    = 2;
    localparam int unsigned OP_MOVC   = 3;
    localparam int unsigned OP_SUB    = 4;
    localparam int unsigned OP_JMPZ   = 5;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [1:0] RF_SEL_ALU   = 2'b00;
    localparam logic [1:0] RF_SEL_MEM   = 2'b01;
    localparam logic [1:0] RF_SEL_CONST = 2'b10;

    // HALT is always the all-ones opcode, whatever the opcode width.
    function automatic logic is_halt_op(input logic [31:0] opcode, input int unsigned op_w);
        logic [31:0] mask_v;
        mask_v = (32'd1 << op_w) - 32'd1;
        return (opcode & mask_v) == mask_v;
    endfunction

endpackage

// File: rtl/proc_controller_p_ack_watchdog.sv
// Counts consecutive cycles spent waiting for a memory acknowledge and
// flags a timeout on the last permitted cycle unless the ack arrives.
module ack_watchdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("ack_watchdog: MAX_WAIT must be at least 1");
    end

    logic [CNT_W-1:0] wait_cnt_r;

    // Timeout condition: still waiting, no ack, and the budget is used up.
    always_comb begin
        timeout = 1'b0;
        if (enable && !ack && (wait_cnt_r == LAST_WAIT)) begin
            timeout = 1'b1;
        end else begin
            timeout = 1'b0;
        end
    end

    // Wait counter: restarts on every state change, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (enable && !ack && (wait_cnt_r != LAST_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

endmodule

// File: rtl/proc_controller_p.sv
// Control unit for the programmable processor: fetch/decode/execute
// sequencing with handshaked memories, HALT, and an ack watchdog.
module proc_controller_p
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned IW       = 16,
    parameter int unsigned OP_W     = 4,
    parameter int unsigned RA_W     = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   instr,
    input  logic            i_ack,
    input  logic            d_ack,
    input  logic            RF_Rp_zero,
    output logic            I_rd,
    output logic            IR_ld,
    output logic            PC_clr,
    output logic            PC_inc,
    output logic            PC_ld,
    output logic            D_rd,
    output logic            D_wr,
    output logic            RF_s1,
    output logic            RF_s0,
    output logic            RF_W_wr,
    output logic            RF_Rp_rd,
    output logic            RF_Rq_rd,
    output logic            alu_s1,
    output logic            alu_s0,
    output logic [RA_W-1:0] RF_W_addr,
    output logic [RA_W-1:0] RF_Rp_addr,
    output logic [RA_W-1:0] RF_Rq_addr,
    output logic            halted,
    output logic            bus_err,
    output logic            illegal_op
);

    if (IW < OP_W + 3 * RA_W) begin : g_bad_width
        $error("proc_controller_p: IW must be >= OP_W + 3*RA_W");
    end

    state_t            state_r;
    state_t            state_s;
    logic              halted_r;
    logic              bus_err_r;
    logic              timeout_s;
    logic              wd_enable_s;
    logic              wd_ack_s;
    logic              wd_clear_s;
    logic [OP_W-1:0]   opcode_s;
    logic [RA_W-1:0]   ra_s;
    logic [RA_W-1:0]   rb_s;
    logic [RA_W-1:0]   rc_s;

    assign opcode_s = instr[IW-1 -: OP_W];
    assign ra_s     = instr[IW-OP_W-1 -: RA_W];
    assign rb_s     = instr[IW-OP_W-RA_W-1 -: RA_W];
    assign rc_s     = instr[IW-OP_W-2*RA_W-1 -: RA_W];

    // Watchdog hookup: only the three handshake states consume wait budget.
    always_comb begin
        wd_enable_s = 1'b0;
        wd_ack_s    = 1'b0;
        wd_clear_s  = (state_s != state_r);
        case (state_r)
            FETCH: begin
                wd_enable_s = 1'b1;
                wd_ack_s    = i_ack;
            end
            MOVRD, MOVDR: begin
                wd_enable_s = 1'b1;
                wd_ack_s    = d_ack;
            end
            default: begin
                wd_enable_s = 1'b0;
                wd_ack_s    = 1'b0;
            end
        endcase
    end

    ack_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .ack     (wd_ack_s),
        .timeout (timeout_s)
    );

    // Next-state and strobe decode; every output starts at 0 each cycle.
    always_comb begin
        state_s    = state_r;
        I_rd       = 1'b0;
        IR_ld      = 1'b0;
        PC_clr     = 1'b0;
        PC_inc     = 1'b0;
        PC_ld      = 1'b0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s1      = 1'b0;
        RF_s0      = 1'b0;
        RF_W_wr    = 1'b0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_rd   = 1'b0;
        alu_s1     = 1'b0;
        alu_s0     = 1'b0;
        RF_W_addr  = {RA_W{1'b0}};
        RF_Rp_addr = {RA_W{1'b0}};
        RF_Rq_addr = {RA_W{1'b0}};
        illegal_op = 1'b0;
        case (state_r)
            INIT: begin
                PC_clr  = 1'b1;
                state_s = FETCH;
            end
            FETCH: begin
                I_rd = 1'b1;
                if (i_ack) begin
                    IR_ld   = 1'b1;
                    PC_inc  = 1'b1;
                    state_s = DECODE;
                end else if (timeout_s) begin
                    state_s = HALT;
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: begin
                if (is_halt_op(32'(opcode_s), OP_W)) begin
                    state_s = HALT;
                end else begin
                    case (opcode_s)
                        OP_W'(OP_MOV_RD): state_s = MOVRD;
                        OP_W'(OP_MOV_DR): state_s = MOVDR;
                        OP_W'(OP_ADD):    state_s = ADD;
                        OP_W'(OP_MOVC):   state_s = MOVRC;
                        OP_W'(OP_SUB):    state_s = SUB;
                        OP_W'(OP_JMPZ):   state_s = JMPZ;
                        default: begin
                            illegal_op = 1'b1;
                            state_s    = FETCH;
                        end
                    endcase
                end
            end
            MOVRD: begin
                D_rd           = 1'b1;
                {RF_s1, RF_s0} = RF_SEL_MEM;
                RF_W_addr      = ra_s;
                if (d_ack) begin
                    RF_W_wr = 1'b1;
                    state_s = FETCH;
                end else if (timeout_s) begin
                    state_s = HALT;
                end else begin
                    state_s = MOVRD;
                end
            end
            MOVDR: begin
                D_wr       = 1'b1;
                RF_Rp_rd   = 1'b1;
                RF_Rp_addr = ra_s;
                if (d_ack) begin
                    state_s = FETCH;
                end else if (timeout_s) begin
                    state_s = HALT;
                end else begin
                    state_s = MOVDR;
                end
            end
            ADD, SUB: begin
                RF_Rp_rd         = 1'b1;
                RF_Rq_rd         = 1'b1;
                RF_W_wr          = 1'b1;
                RF_Rp_addr       = rb_s;
                RF_Rq_addr       = rc_s;
                RF_W_addr        = ra_s;
                {RF_s1, RF_s0}   = RF_SEL_ALU;
                {alu_s1, alu_s0} = (state_r == ADD) ? ALU_ADD : ALU_SUB;
                state_s          = FETCH;
            end
            MOVRC: begin
                {RF_s1, RF_s0} = RF_SEL_CONST;
                RF_W_wr        = 1'b1;
                RF_W_addr      = ra_s;
                state_s        = FETCH;
            end
            JMPZ: begin
                RF_Rp_rd   = 1'b1;
                RF_Rp_addr = ra_s;
                PC_ld      = RF_Rp_zero;
                state_s    = FETCH;
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s = INIT;
            end
        endcase
    end

    // State register plus the sticky halted / bus-error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= INIT;
            halted_r  <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_s == HALT) begin
                halted_r <= 1'b1;
            end
            if (timeout_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign halted  = halted_r;
    assign bus_err = bus_err_r;

endmodule

// File: doc/proc_controller_p.md
Name: proc_controller_p

Overview:
- Parametrised next-generation control unit for the six-instruction programmable processor.
- Sequences fetch, decode and execute for MOV Ra,d / MOV d,Ra / ADD / MOV Ra,C / SUB / JMPZ, plus a new HALT instruction.
- Supports variable-latency instruction and data memories through ready/ack handshakes, with a watchdog timeout.
- Sits between the instruction register, PC, register file, ALU and data memory. It drives only control strobes and register-file addresses.

Parameters:
- IW, 16, instruction width.
- OP_W, 4, opcode width; opcode is instr[IW-1 -: OP_W].
- RA_W, 4, register-file address width. Fields: ra = instr[IW-OP_W-1 -: RA_W], rb = next RA_W bits down, rc = next RA_W bits down. Elaboration error unless IW >= OP_W + 3*RA_W.
- MAX_WAIT, 15, maximum cycles to wait for i_ack/d_ack before bus error; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- instr  in  IW  current instruction-register contents.
- i_ack  in  1  instruction memory has valid data this cycle.
- d_ack  in  1  data memory completed the read/write this cycle.
- RF_Rp_zero  in  1  Rp read port equals zero.
- I_rd, IR_ld, PC_clr, PC_inc, PC_ld  out  1 each  instruction-path strobes.
- D_rd, D_wr  out  1 each  data-memory strobes.
- RF_s1, RF_s0, RF_W_wr, RF_Rp_rd, RF_Rq_rd  out  1 each  register-file mux select and enables.
- alu_s1, alu_s0  out  1 each  ALU op (01 add, 10 sub, 00 pass).
- RF_W_addr, RF_Rp_addr, RF_Rq_addr  out  RA_W each  register addresses.
- halted  out  1  processor stopped (HALT or bus error); sticky until rst.
- bus_err  out  1  ack timeout occurred; sticky until rst.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Single registered state plus wait counter. All outputs are combinational from state, instr, i_ack, d_ack and RF_Rp_zero. There are no latches; every output is defaulted to 0 each cycle.
- rst sampled high: state <= INIT, wait_cnt <= 0, halted/bus_err <= 0. Reset mid-instruction aborts with no further strobes.
- During INIT, all outputs are 0 except PC_clr=1.
- INIT -> FETCH unconditionally.
- FETCH: I_rd=1.
  - i_ack=0: stay and increment wait_cnt.
  - i_ack=1: same cycle IR_ld=1, PC_inc=1 -> DECODE.
- DECODE: 1 cycle, no strobes; branches on opcode.
  - 0000 -> MOVRD, 0001 -> MOVDR, 0010 -> ADD, 0011 -> MOVRC, 0100 -> SUB, 0101 -> JMPZ, all-ones -> HALT.
  - Any other opcode: illegal_op=1 this cycle -> FETCH.
- MOVRD: D_rd=1, RF_s1..0=01, RF_W_addr=ra. Wait for d_ack; RF_W_wr=1 only in the d_ack cycle -> FETCH.
- MOVDR: D_wr=1, RF_Rp_rd=1, RF_Rp_addr=ra, held until the d_ack cycle -> FETCH.
- ADD / SUB: 1 cycle.
  - RF_Rp_rd=RF_Rq_rd=RF_W_wr=1; Rp=rb, Rq=rc, W=ra; RF_s=00.
  - alu_s=01 (ADD) or 10 (SUB) -> FETCH.
- MOVRC: 1 cycle. RF_s=10, RF_W_wr=1, W=ra -> FETCH.
- JMPZ: 1 cycle. RF_Rp_rd=1, Rp=ra, PC_ld=RF_Rp_zero -> FETCH.
- HALT: halted=1, all strobes 0, remain until rst. i_ack/d_ack are ignored.
- Watchdog:
  - wait_cnt clears on every state change.
  - In FETCH/MOVRD/MOVDR without ack, when wait_cnt == MAX_WAIT-1: bus_err <= 1 -> HALT. The pending strobe drops the next cycle.
  - An ack arriving in the same cycle as the timeout wins: normal transition, no error.
- Instruction latency with zero-wait memories (ack same cycle as request): 3 cycles for ALU/MOVRC/JMPZ (FETCH, DECODE, EXEC) and 3 cycles for memory ops. Each additional wait cycle adds 1.
- PC_ld and PC_inc are never asserted in the same cycle.
- RF_W_wr is never asserted in FETCH/DECODE.

Decomposition:
- Package proc_ctrl_pkg: opcode constants (OP_MOV_RD=0, OP_MOV_DR=1, OP_ADD=2, OP_MOVC=3, OP_SUB=4, OP_JMPZ=5, OP_HALT=all-ones), state enum {INIT, FETCH, DECODE, MOVRD, MOVDR, ADD, MOVRC, SUB, JMPZ, HALT}, ALU select constants.
- Sub-module ack_watchdog: clear/enable/ack inputs, MAX_WAIT parameter, timeout output, counter width $clog2(MAX_WAIT+1).

Test Plan:
- Reset then i_ack tied 1:
  - cycle after rst: PC_clr=1.
  - next cycle: I_rd=IR_ld=PC_inc=1.
  - then DECODE quiet.
- instr=16'h2312 (ADD R3,R1,R2): EXEC cycle shows RF_Rp_addr=1, RF_Rq_addr=2, RF_W_addr=3, alu_s=01, RF_W_wr=1 for exactly 1 cycle.
- instr=16'h0507 with d_ack delayed 4 cycles: D_rd high 5 cycles, RF_W_wr high only in the 5th, RF_W_addr=5.
- instr=16'h5400:
  - RF_Rp_zero=1: PC_ld=1, PC_inc=0 in EXEC.
  - repeat with RF_Rp_zero=0: PC_ld stays 0.
- i_ack held 0 with MAX_WAIT=15: bus_err and halted rise after 15 FETCH cycles, I_rd then 0; rst recovers to INIT.
- instr=16'h9000: illegal_op pulses 1 cycle, then FETCH. instr=16'hF000: halted=1 and stays high.
